// File: rtl/pc_sequencer.sv
// Next-PC control sequencer. Fetches the instruction at pc_in, decodes
// jump/branch/halt opcodes, launches the ALU when a result or a compare is
// needed, and presents exactly one non-hold PC mux select per instruction.
module pc_sequencer #(
   parameter logic [5:0] OP_J    = 6'h02,
   parameter logic [5:0] OP_BEQ  = 6'h04,
   parameter logic [5:0] OP_BNE  = 6'h05,
   parameter logic [5:0] OP_HALT = 6'h3F
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pc_in,
   output logic        imem_req,
   input  logic        imem_ready,
   input  logic [31:0] instr,
   output logic        alu_start,
   input  logic        alu_done,
   input  logic        alu_zero,
   input  logic        stall,
   output logic [1:0]  pc_sel,
   output logic [31:0] jump_target,
   output logic [31:0] branch_target,
   output logic [31:0] instr_reg,
   output logic        halted
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      BRWAIT = 3'd3,
      UPDATE = 3'd4,
      HALT   = 3'd5
   } stateT;

   localparam logic [1:0] SEL_HOLD   = 2'b00;
   localparam logic [1:0] SEL_JUMP   = 2'b01;
   localparam logic [1:0] SEL_BRANCH = 2'b10;
   localparam logic [1:0] SEL_PLUS4  = 2'b11;

   stateT       stateR;
   stateT       stateNextS;
   logic [1:0]  pendSelR;
   logic [1:0]  pendSelNextS;
   logic        isBneR;
   logic [31:0] instrR;
   logic [31:0] jumpTargetR;
   logic [31:0] branchTargetR;
   logic [5:0]  opcodeS;
   logic [1:0]  pcSelS;
   logic        imemReqS;
   logic        aluStartS;
   logic        haltedS;
   logic        takeBranchS;

   // Jump address: upper nibble of the sequential PC plus the word index.
   function automatic logic [31:0] calcJump(input logic [31:0] pc, input logic [31:0] ir);
      logic [31:0] pcPlus4;
      pcPlus4 = pc + 32'd4;
      return {pcPlus4[31:28], ir[25:0], 2'b00};
   endfunction

   // Branch address: sequential PC plus sign-extended word offset, wrapping.
   function automatic logic [31:0] calcBranch(input logic [31:0] pc, input logic [31:0] ir);
      return pc + 32'd4 + {{14{ir[15]}}, ir[15:0], 2'b00};
   endfunction

   assign opcodeS     = instrR[31:26];
   assign takeBranchS = isBneR ? ~alu_zero : alu_zero;

   // State register; reset always returns to FETCH and drops any pending update.
   always_ff @(posedge clock) begin
      if (reset) begin
         stateR <= FETCH;
      end else begin
         stateR <= stateNextS;
      end
   end

   // Instruction latch, decoded targets and the pending PC select.
   always_ff @(posedge clock) begin
      if (reset) begin
         instrR        <= 32'd0;
         jumpTargetR   <= 32'd0;
         branchTargetR <= 32'd0;
         isBneR        <= 1'b0;
         pendSelR      <= SEL_HOLD;
      end else begin
         if (stateR == FETCH && imem_ready) begin
            instrR <= instr;
         end
         if (stateR == DECODE) begin
            jumpTargetR   <= calcJump(pc_in, instrR);
            branchTargetR <= calcBranch(pc_in, instrR);
            isBneR        <= (opcodeS == OP_BNE);
         end
         pendSelR <= pendSelNextS;
      end
   end

   // Next-state and control outputs; pc_sel leaves hold only in an unstalled UPDATE.
   always_comb begin
      stateNextS   = stateR;
      pendSelNextS = pendSelR;
      pcSelS       = SEL_HOLD;
      imemReqS     = 1'b0;
      aluStartS    = 1'b0;
      haltedS      = 1'b0;
      case (stateR)
         FETCH: begin
            imemReqS = 1'b1;
            if (imem_ready) begin
               stateNextS = DECODE;
            end else begin
               stateNextS = FETCH;
            end
         end
         DECODE: begin
            if (opcodeS == OP_J) begin
               pendSelNextS = SEL_JUMP;
               stateNextS   = UPDATE;
            end else if (opcodeS == OP_BEQ || opcodeS == OP_BNE) begin
               aluStartS  = 1'b1;
               stateNextS = BRWAIT;
            end else if (opcodeS == OP_HALT) begin
               stateNextS = HALT;
            end else begin
               aluStartS  = 1'b1;
               stateNextS = EXEC;
            end
         end
         EXEC: begin
            if (alu_done) begin
               pendSelNextS = SEL_PLUS4;
               stateNextS   = UPDATE;
            end else begin
               stateNextS = EXEC;
            end
         end
         BRWAIT: begin
            if (alu_done) begin
               pendSelNextS = takeBranchS ? SEL_BRANCH : SEL_PLUS4;
               stateNextS   = UPDATE;
            end else begin
               stateNextS = BRWAIT;
            end
         end
         UPDATE: begin
            if (!stall) begin
               pcSelS     = pendSelR;
               stateNextS = FETCH;
            end else begin
               pcSelS     = SEL_HOLD;
               stateNextS = UPDATE;
            end
         end
         HALT: begin
            haltedS    = 1'b1;
            stateNextS = HALT;
         end
         default: begin
            stateNextS = FETCH;
         end
      endcase
   end

   // While reset is high every control output is forced quiet.
   assign pc_sel        = reset ? SEL_HOLD : pcSelS;
   assign imem_req      = reset ? 1'b0 : imemReqS;
   assign alu_start     = reset ? 1'b0 : aluStartS;
   assign halted        = reset ? 1'b0 : haltedS;
   assign instr_reg     = instrR;
   assign jump_target   = jumpTargetR;
   assign branch_target = branchTargetR;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each directed instruction pushes its
// expected select and target; a monitor pops and compares on every pc_sel pulse.
module tb_pc_sequencer;

   logic        clock;
   logic        reset;
   logic [31:0] pc_in;
   logic        imem_req;
   logic        imem_ready;
   logic [31:0] instr;
   logic        alu_start;
   logic        alu_done;
   logic        alu_zero;
   logic        stall;
   logic [1:0]  pc_sel;
   logic [31:0] jump_target;
   logic [31:0] branch_target;
   logic [31:0] instr_reg;
   logic        halted;

   typedef struct {
      logic [1:0]  sel;
      bit          isJump;
      logic [31:0] target;
   } expT;

   expT sb[$];
   int  checks = 0;
   int  passes = 0;

   pc_sequencer dut (
      .clock(clock), .reset(reset), .pc_in(pc_in), .imem_req(imem_req),
      .imem_ready(imem_ready), .instr(instr), .alu_start(alu_start),
      .alu_done(alu_done), .alu_zero(alu_zero), .stall(stall), .pc_sel(pc_sel),
      .jump_target(jump_target), .branch_target(branch_target),
      .instr_reg(instr_reg), .halted(halted)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      else passes++;
   endtask

   // Monitor: every non-hold select must match the oldest expected entry.
   initial begin
      expT e;
      forever begin
         @(negedge clock);
         #2;
         if (pc_sel !== 2'b00) begin
            if (sb.size() == 0) begin
               chk("unexpected_pc_sel", {30'd0, pc_sel}, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("pc_sel", {30'd0, pc_sel}, {30'd0, e.sel});
               if (e.isJump) chk("jump_target", jump_target, e.target);
               else          chk("branch_target", branch_target, e.target);
            end
         end
      end
   end

   task automatic runInstr(input string nm, input logic [31:0] pc, input logic [31:0] w,
                           input int rdyDly, input int doneDly, input bit zero,
                           input int stallUntil, input logic [1:0] expSel, input bit isJump,
                           input logic [31:0] tgt, input int expLat, input int expStarts);
      int cyc = 0, req = 0, aluCnt = 0, starts = 0;
      bit armed = 1'b0, got = 1'b0;
      expT e;
      e.sel = expSel; e.isJump = isJump; e.target = tgt;
      sb.push_back(e);
      pc_in = pc; instr = w; alu_zero = zero;
      while (!got && cyc < 100) begin
         @(negedge clock);
         cyc++;
         imem_ready = 1'b0;
         alu_done   = 1'b0;
         if (imem_req) begin
            imem_ready = (req == rdyDly);
            req++;
         end
         if (armed) begin
            aluCnt++;
            alu_done = (aluCnt == doneDly);
         end
         if (alu_start) begin
            starts++;
            armed  = 1'b1;
            aluCnt = 0;
         end
         stall = (cyc <= stallUntil);
         #1;
         if (pc_sel !== 2'b00) got = 1'b1;
      end
      imem_ready = 1'b0; alu_done = 1'b0; stall = 1'b0;
      if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
      else      chk({nm, "_latency"}, cyc, expLat);
      chk({nm, "_alu_starts"}, starts, expStarts);
   endtask

   initial begin
      int starts;
      reset = 1'b1; pc_in = 32'd0; imem_ready = 1'b0; instr = 32'd0;
      alu_done = 1'b0; alu_zero = 1'b0; stall = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_pc_sel", {30'd0, pc_sel}, 32'd0);
      chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
      chk("rst_alu_start", {31'd0, alu_start}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_instr_reg", instr_reg, 32'd0);
      chk("rst_jump_target", jump_target, 32'd0);
      chk("rst_branch_target", branch_target, 32'd0);
      reset = 1'b0;

      // name, pc, instr, rdy, done, zero, stallUntil, sel, isJump, target, latency, starts
      runInstr("j",        32'h0000_0000, 32'h0800_0010, 0, 0, 1'b0, 0, 2'b01, 1'b1, 32'h0000_0040, 3, 0);
      runInstr("beq_take", 32'h0000_0100, 32'h1022_FFFF, 0, 1, 1'b1, 0, 2'b10, 1'b0, 32'h0000_0100, 4, 1);
      runInstr("beq_fall", 32'h0000_0100, 32'h1022_FFFF, 0, 1, 1'b0, 0, 2'b11, 1'b0, 32'h0000_0100, 4, 1);
      runInstr("bne_wrap", 32'hFFFF_FFFC, 32'h1422_0003, 0, 1, 1'b0, 0, 2'b10, 1'b0, 32'h0000_000C, 4, 1);
      runInstr("bne_fall", 32'h0000_0040, 32'h1422_0003, 0, 1, 1'b1, 0, 2'b11, 1'b0, 32'h0000_0050, 4, 1);
      runInstr("alu_slow", 32'h0000_0200, 32'h0022_1820, 3, 5, 1'b0, 0, 2'b11, 1'b0, 32'h0000_6284, 11, 1);
      runInstr("j_stall",  32'h1000_0000, 32'h0800_0123, 0, 0, 1'b0, 6, 2'b01, 1'b1, 32'h1000_048C, 7, 0);

      // Reset while the BEQ waits for the ALU: no select may escape.
      pc_in = 32'h0000_0300; instr = 32'h1022_0004; alu_zero = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         imem_ready = imem_req;
      end
      imem_ready = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("rstmid_pc_sel", {30'd0, pc_sel}, 32'd0);
      @(negedge clock);
      chk("rstmid_instr_reg", instr_reg, 32'd0);
      chk("rstmid_branch_target", branch_target, 32'd0);
      chk("rstmid_jump_target", jump_target, 32'd0);
      chk("rstmid_imem_req", {31'd0, imem_req}, 32'd0);
      reset = 1'b0;
      alu_done = 1'b1;
      repeat (3) @(negedge clock);
      chk("rstmid_stay_fetch", {31'd0, imem_req}, 32'd1);
      alu_done = 1'b0;

      // Halt: sequencing stops, halted rises, fetch stops.
      pc_in = 32'h0000_0400; instr = 32'hFC00_0000;
      starts = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         imem_ready = imem_req;
         if (alu_start) starts++;
      end
      imem_ready = 1'b0;
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_imem_req", {31'd0, imem_req}, 32'd0);
      chk("halt_alu_starts", starts, 32'd0);
      chk("halt_pc_sel", {30'd0, pc_sel}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("halt_rst_halted", {31'd0, halted}, 32'd0);
      reset = 1'b0;

      runInstr("j_after",  32'h2000_0008, 32'h0800_0001, 0, 0, 1'b0, 0, 2'b01, 1'b1, 32'h2000_0004, 3, 0);

      repeat (3) @(negedge clock);
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
